// File: rtl/issue_pkg.sv
// issue_pkg: shared definitions for the decode-to-execute issue controller.
//
// Holds the decoder one-hot signal bit positions, the register file geometry,
// the issue FSM state enum, the hold/payload record types and small
// classification helpers used by issue_ctrl and issue_scoreboard.
package issue_pkg;

    localparam int SIG_W     = 37;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    // Loads
    localparam int SIG_LB   = 19;
    localparam int SIG_LH   = 20;
    localparam int SIG_LW   = 21;
    localparam int SIG_LBU  = 22;
    localparam int SIG_LHU  = 23;
    // Stores
    localparam int SIG_SB   = 24;
    localparam int SIG_SH   = 25;
    localparam int SIG_SW   = 26;
    // Conditional branches
    localparam int SIG_BEQ  = 27;
    localparam int SIG_BNE  = 28;
    localparam int SIG_BLT  = 29;
    localparam int SIG_BGE  = 30;
    localparam int SIG_BLTU = 31;
    localparam int SIG_BGEU = 32;
    // Jumps
    localparam int SIG_JAL  = 33;
    localparam int SIG_JALR = 34;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_BR = 1'b1
    } issue_state_e;

    // Fields that travel from the hold register into the ID/EX register
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [SIG_W-1:0]     sig;
        logic [31:0]          imm;
        logic [31:0]          pc;
    } payload_t;

    // Hold entry: the payload plus the bits only needed for hazard checks
    typedef struct packed {
        logic     valid;
        logic     rs1_valid;
        logic     rs2_valid;
        payload_t p;
    } hold_t;

    function automatic logic sig_is_load(input logic [SIG_W-1:0] sig);
        return |sig[SIG_LHU:SIG_LB];
    endfunction

    function automatic logic sig_is_store(input logic [SIG_W-1:0] sig);
        return |sig[SIG_SW:SIG_SB];
    endfunction

    function automatic logic sig_is_branch(input logic [SIG_W-1:0] sig);
        return |sig[SIG_BGEU:SIG_BEQ];
    endfunction

    function automatic logic sig_is_jump(input logic [SIG_W-1:0] sig);
        return |sig[SIG_JALR:SIG_JAL];
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-load register scoreboard.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en, set_idx     mark a register busy (an issuing load)
//   clr_en, clr_idx     load writeback, clears the busy bit
//   busy                registered busy vector, bit 0 always 0
//   busy_eff            busy vector as seen by hazard detection
//
// Build option: ISSUE_WB_BYPASS_EN defined lets a writeback in the current
// cycle hide its busy bit from busy_eff so a dependent can issue at once.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]  busy,
    output logic [NUM_REGS-1:0]  busy_eff
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Set is OR-ed in after the clear so it wins on a same-index collision;
    // x0 is never tracked.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign busy_eff = busy_q & ~clr_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign busy = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-to-execute issue controller.
//
// Buffers one decoded instruction in a hold register, stalls it on RAW/WAW
// hazards against pending loads, serializes branches/jumps until execute
// resolves them, and drives the registered ID/EX payload.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          decoder handshake
//   in_rs1/_valid, in_rs2/_valid, in_rd, in_sig, in_imm, in_pc  decoded fields
//   out_valid/out_ready        execute handshake
//   out_rs1..out_pc            registered ID/EX payload
//   wb_valid, wb_rd            load writeback, clears a scoreboard bit
//   br_resolve, br_taken       control-flow resolution from execute
//   busy                       scoreboard vector
//   stall_cnt                  saturating hazard-stall cycle counter
//
// Build option: ISSUE_WB_BYPASS_EN (see issue_scoreboard) allows a dependent
// instruction to issue in the same cycle as its load writeback.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs1,
    input  logic                   in_rs1_valid,
    input  logic [4:0]             in_rs2,
    input  logic                   in_rs2_valid,
    input  logic [4:0]             in_rd,
    input  logic [SIG_W-1:0]       in_sig,
    input  logic [31:0]            in_imm,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic [SIG_W-1:0]       out_sig,
    output logic [31:0]            out_imm,
    output logic [31:0]            out_pc,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   br_resolve,
    input  logic                   br_taken,
    output logic [31:0]            busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hold_t                  h_q, h_d;
    payload_t               out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    issue_state_e           state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_REGS-1:0] busy_eff;
    logic h_is_load, h_ctrl_flow, h_writes_rd;
    logic hazard, issue, accept, sb_set_en;
    logic run_mode, flush_hold;

    // Classify the instruction sitting in the hold register
    always_comb begin
        h_is_load   = sig_is_load(h_q.p.sig);
        h_ctrl_flow = sig_is_branch(h_q.p.sig) || sig_is_jump(h_q.p.sig);
        h_writes_rd = !sig_is_store(h_q.p.sig) && !sig_is_branch(h_q.p.sig)
                      && (h_q.p.rd != '0);
    end

    // RAW on either source, WAW on the destination
    always_comb begin
        hazard = 1'b0;
        if (h_q.rs1_valid && busy_eff[h_q.p.rs1]) hazard = 1'b1;
        if (h_q.rs2_valid && busy_eff[h_q.p.rs2]) hazard = 1'b1;
        if (h_writes_rd  && busy_eff[h_q.p.rd])   hazard = 1'b1;
    end

    assign issue     = h_q.valid && !hazard && run_mode && (!out_valid_q || out_ready);
    assign in_ready  = !h_q.valid || issue;
    assign accept    = in_valid && in_ready;
    assign sb_set_en = issue && h_is_load && (h_q.p.rd != '0);

    issue_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set_en),
        .set_idx  (h_q.p.rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .busy     (busy),
        .busy_eff (busy_eff)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM next state: a resolve seen while running is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (issue && h_ctrl_flow) state_d = WAIT_BR;
            WAIT_BR: if (br_resolve)           state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_mode   = (state_q == RUN);
        flush_hold = (state_q == WAIT_BR) && br_resolve && br_taken;
    end

    // Hold register: a taken resolve drops both the held entry and anything
    // accepted on the same edge, since both are wrong-path.
    always_comb begin
        h_d = h_q;
        if (flush_hold) begin
            h_d.valid = 1'b0;
        end else if (accept) begin
            h_d.valid     = 1'b1;
            h_d.rs1_valid = in_rs1_valid;
            h_d.rs2_valid = in_rs2_valid;
            h_d.p.rs1     = in_rs1;
            h_d.p.rs2     = in_rs2;
            h_d.p.rd      = in_rd;
            h_d.p.sig     = in_sig;
            h_d.p.imm     = in_imm;
            h_d.p.pc      = in_pc;
        end else if (issue) begin
            h_d.valid = 1'b0;
        end
    end

    // ID/EX register: payload only changes on issue so it holds under backpressure
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (issue) begin
            out_d       = h_q.p;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating count of hazard stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (h_q.valid && hazard && run_mode && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            h_q         <= h_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rs1   = out_q.rs1;
    assign out_rs2   = out_q.rs2;
    assign out_rd    = out_q.rd;
    assign out_sig   = out_q.sig;
    assign out_imm   = out_q.imm;
    assign out_pc    = out_q.pc;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: self-checking bench for issue_ctrl.
//
// A cycle-level reference model tracks the held instruction, the issued
// instruction, the set of registers with loads in flight, the branch-wait
// flag and the stall count; it is stepped alongside the DUT for directed
// scenarios and a randomized run. Honors ISSUE_WB_BYPASS_EN.
module tb_issue_ctrl;

    localparam int SCW = 4;
    localparam int SAT = (1 << SCW) - 1;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP} kind_e;

    typedef struct {
        bit          valid;
        kind_e       kind;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        bit          rs1v;
        bit          rs2v;
        logic [36:0] sig;
        logic [31:0] imm;
        logic [31:0] pc;
    } instr_t;

    logic           clk, rst_n;
    logic           in_valid, in_ready;
    logic [4:0]     in_rs1, in_rs2, in_rd;
    logic           in_rs1_valid, in_rs2_valid;
    logic [36:0]    in_sig;
    logic [31:0]    in_imm, in_pc;
    logic           out_valid, out_ready;
    logic [4:0]     out_rs1, out_rs2, out_rd;
    logic [36:0]    out_sig;
    logic [31:0]    out_imm, out_pc;
    logic           wb_valid;
    logic [4:0]     wb_rd;
    logic           br_resolve, br_taken;
    logic [31:0]    busy;
    logic [SCW-1:0] stall_cnt;

    issue_ctrl #(.STALL_CNT_W(SCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs1_valid (in_rs1_valid),
        .in_rs2       (in_rs2),
        .in_rs2_valid (in_rs2_valid),
        .in_rd        (in_rd),
        .in_sig       (in_sig),
        .in_imm       (in_imm),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_sig      (out_sig),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .br_resolve   (br_resolve),
        .br_taken     (br_taken),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    instr_t cur_in;
    instr_t m_hold, m_out;
    bit     m_out_valid, m_wait;
    bit     m_pend [32];
    int     m_stall;
    bit     m_issue, m_in_ready, m_blocked;

    function automatic instr_t nopInstr();
        instr_t n;
        n.valid = 0; n.kind = K_ALU; n.rs1 = 0; n.rs2 = 0; n.rd = 0;
        n.rs1v = 0; n.rs2v = 0; n.sig = 0; n.imm = 0; n.pc = 0;
        return n;
    endfunction

    // One-hot decoder vector for an instruction kind; sel picks the variant
    function automatic logic [36:0] sigFor(kind_e k, int sel);
        logic [36:0] v;
        int b;
        v = '0;
        case (k)
            K_ALU:    begin b = sel % 21; if (b >= 19) b = b - 19 + 35; end
            K_LOAD:   b = 19 + sel % 5;
            K_STORE:  b = 24 + sel % 3;
            K_BRANCH: b = 27 + sel % 6;
            default:  b = 33 + sel % 2;
        endcase
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic instr_t mk(kind_e k, int rd, int rs1, int rs2, int sel);
        instr_t n;
        n.valid = 1;
        n.kind  = k;
        n.rd    = 5'(rd);
        n.rs1   = 5'(rs1);
        n.rs2   = 5'(rs2);
        n.sig   = sigFor(k, sel);
        n.rs1v  = !(k == K_JUMP && sel % 2 == 0);
        n.rs2v  = (k == K_STORE) || (k == K_BRANCH) || (k == K_ALU && sel % 2 == 1);
        n.imm   = $urandom;
        n.pc    = $urandom & 32'hFFFF_FFFC;
        return n;
    endfunction

    function automatic logic [31:0] packPend();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic modelReset();
        m_hold      = nopInstr();
        m_out       = nopInstr();
        m_out_valid = 0;
        m_wait      = 0;
        m_stall     = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    // Decide from the rules whether the held instruction may leave this cycle
    task automatic modelComb();
        bit view [32];
        bit blk, writes;
        view = m_pend;
`ifdef ISSUE_WB_BYPASS_EN
        if (wb_valid) view[wb_rd] = 0;
`endif
        writes = (m_hold.kind != K_STORE) && (m_hold.kind != K_BRANCH) && (m_hold.rd != 0);
        blk = (m_hold.rs1v && view[m_hold.rs1]) || (m_hold.rs2v && view[m_hold.rs2])
              || (writes && view[m_hold.rd]);
        m_blocked  = m_hold.valid && blk;
        m_issue    = m_hold.valid && !blk && !m_wait && (!m_out_valid || out_ready);
        m_in_ready = !m_hold.valid || m_issue;
    endtask

    task automatic modelSeq();
        bit acc, drop, issued;
        instr_t h;
        acc    = in_valid && m_in_ready;
        drop   = m_wait && br_resolve && br_taken;
        issued = m_issue;
        h      = m_hold;
        if (m_blocked && !m_wait && m_stall < SAT) m_stall++;
        if (wb_valid) m_pend[wb_rd] = 0;
        if (issued && h.kind == K_LOAD && h.rd != 0) m_pend[h.rd] = 1;
        if (issued) begin
            m_out = h;
            m_out_valid = 1;
        end else if (out_ready) begin
            m_out_valid = 0;
        end
        if (m_wait) begin
            if (br_resolve) m_wait = 0;
        end else if (issued && (h.kind == K_BRANCH || h.kind == K_JUMP)) begin
            m_wait = 1;
        end
        if (drop) m_hold.valid = 0;
        else if (acc) begin
            m_hold = cur_in;
            m_hold.valid = 1;
        end else if (issued) m_hold.valid = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("out_valid", out_valid, m_out_valid);
        checkOutput("out_rs1", out_rs1, m_out.rs1);
        checkOutput("out_rs2", out_rs2, m_out.rs2);
        checkOutput("out_rd", out_rd, m_out.rd);
        checkOutput("out_sig", out_sig, m_out.sig);
        checkOutput("out_imm", out_imm, m_out.imm);
        checkOutput("out_pc", out_pc, m_out.pc);
        checkOutput("busy", busy, packPend());
        checkOutput("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic stepCycle();
        #1;
        modelComb();
        checkOutput("in_ready", in_ready, m_in_ready);
        modelSeq();
        @(posedge clk);
        #1;
        checkState();
    endtask

    task automatic applyStimulus(input bit v, input instr_t ins, input bit ordy,
                                 input bit wbv, input int wbr, input bit brr, input bit brt);
        cur_in       = ins;
        in_valid     = v;
        in_rs1       = ins.rs1;
        in_rs1_valid = ins.rs1v;
        in_rs2       = ins.rs2;
        in_rs2_valid = ins.rs2v;
        in_rd        = ins.rd;
        in_sig       = ins.sig;
        in_imm       = ins.imm;
        in_pc        = ins.pc;
        out_ready    = ordy;
        wb_valid     = wbv;
        wb_rd        = 5'(wbr);
        br_resolve   = brr;
        br_taken     = brt;
        stepCycle();
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(0, nopInstr(), ordy, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        cur_in = nopInstr();
        in_valid = 0; in_rs1 = 0; in_rs1_valid = 0; in_rs2 = 0; in_rs2_valid = 0;
        in_rd = 0; in_sig = 0; in_imm = 0; in_pc = 0; out_ready = 1;
        wb_valid = 0; wb_rd = 0; br_resolve = 0; br_taken = 0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkState();
        checkOutput("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t ins;
        int     r;

        // Back-to-back independent ALU ops
        doReset();
        applyStimulus(1, mk(K_ALU, 1, 0, 0, 0), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 2, 0, 0, 2), 1, 0, 0, 0, 0);
        checkOutput("b2b_v1", {out_valid, out_rd}, {1'b1, 5'd1});
        applyStimulus(1, mk(K_ALU, 3, 1, 2, 1), 1, 0, 0, 0, 0);
        checkOutput("b2b_v2", {out_valid, out_rd}, {1'b1, 5'd2});
        idle(1);
        checkOutput("b2b_v3", {out_valid, out_rd}, {1'b1, 5'd3});
        idle(1);
        checkOutput("b2b_stall", stall_cnt, 0);

        // Load-use: add x6,x5,x5 waits for the lw x5 writeback
        doReset();
        applyStimulus(1, mk(K_LOAD, 5, 0, 0, 2), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 6, 5, 5, 1), 1, 0, 0, 0, 0);
        checkOutput("lu_busy5", busy[5], 1);
        for (int i = 0; i < 4; i++) idle(1);
        applyStimulus(0, nopInstr(), 1, 1, 5, 0, 0);
`ifdef ISSUE_WB_BYPASS_EN
        checkOutput("lu_issue_wb", {out_valid, out_rd}, {1'b1, 5'd6});
        checkOutput("lu_stall", stall_cnt, 4);
`else
        checkOutput("lu_hold_wb", out_valid, 0);
        idle(1);
        checkOutput("lu_issue_next", {out_valid, out_rd}, {1'b1, 5'd6});
        checkOutput("lu_stall", stall_cnt, 5);
`endif
        idle(1);

        // WAW on x7, then a load to x0 that must not be tracked
        doReset();
        applyStimulus(1, mk(K_LOAD, 7, 1, 0, 0), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 7, 0, 0, 0), 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle(1);
        checkOutput("waw_held", in_ready, 0);
        applyStimulus(0, nopInstr(), 1, 1, 7, 0, 0);
        idle(1);
        idle(1);
        applyStimulus(1, mk(K_LOAD, 0, 1, 0, 4), 1, 0, 0, 0, 0);
        idle(1);
        idle(1);
        checkOutput("x0_busy", busy, 0);

        // Taken branch drops the held wrong-path addi
        doReset();
        applyStimulus(1, mk(K_BRANCH, 0, 1, 2, 0), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 9, 0, 0, 0), 1, 0, 0, 0, 0);
        idle(1);
        idle(1);
        checkOutput("bt_wait_held", in_ready, 0);
        applyStimulus(0, nopInstr(), 1, 0, 0, 1, 1);
        idle(1);
        checkOutput("bt_dropped", out_valid, 0);
        checkOutput("bt_empty", in_ready, 1);
        // A jump, then an instruction accepted in the taken-resolve cycle
        applyStimulus(1, mk(K_JUMP, 1, 0, 0, 0), 1, 0, 0, 0, 0);
        idle(1);
        applyStimulus(1, mk(K_ALU, 10, 0, 0, 0), 1, 0, 0, 1, 1);
        idle(1);
        idle(1);
        checkOutput("bt_acc_dropped", out_valid, 0);

        // Not-taken branch: addi issues the cycle after resolve
        doReset();
        applyStimulus(1, mk(K_BRANCH, 0, 1, 2, 3), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 9, 0, 0, 0), 1, 0, 0, 0, 0);
        idle(1);
        applyStimulus(0, nopInstr(), 1, 0, 0, 1, 0);
        idle(1);
        checkOutput("bnt_issue", {out_valid, out_rd}, {1'b1, 5'd9});

        // Backpressure, then an asynchronous reset in the middle of a stall
        doReset();
        applyStimulus(1, mk(K_ALU, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 2, 0, 0, 0), 0, 0, 0, 0, 0);
        ins = mk(K_ALU, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, ins, 0, 0, 0, 0, 0);
        checkOutput("bp_hold", {out_valid, out_rd}, {1'b1, 5'd1});
        checkOutput("bp_full", in_ready, 0);
        applyStimulus(1, ins, 1, 0, 0, 0, 0);
        idle(1);
        idle(1);
        applyStimulus(1, mk(K_LOAD, 5, 0, 0, 2), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 6, 5, 0, 0), 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle(1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stall", stall_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Stall counter saturation
        doReset();
        applyStimulus(1, mk(K_LOAD, 5, 0, 0, 0), 1, 0, 0, 0, 0);
        applyStimulus(1, mk(K_ALU, 6, 5, 0, 0), 1, 0, 0, 0, 0);
        for (int i = 0; i < SAT + 5; i++) idle(1);
        checkOutput("stall_sat", stall_cnt, SAT);
        applyStimulus(0, nopInstr(), 1, 1, 5, 0, 0);
        idle(1);
        idle(1);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) doReset();
            r = $urandom_range(0, 9);
            ins = mk(r < 4 ? K_ALU : r < 7 ? K_LOAD : r == 7 ? K_STORE : r == 8 ? K_BRANCH : K_JUMP,
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 20));
            applyStimulus($urandom_range(0, 9) < 7, ins, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 7),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
